// File: rtl/sysid_check_pkg.sv
// rtl/sysid_check_pkg.sv - shared state encoding and constants for the SysID boot checker
package sysid_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CHECK,
    DONE
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int RETRY_W = 3;

endpackage

// File: rtl/sysid_check_timer.sv
// rtl/sysid_check_timer.sv - loadable 16-bit wait-cycle counter with expiry flag
module sysid_check_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  // Count consecutive stall cycles; load returns the counter to zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // Flags the cycle that would make LIMIT stall cycles in a row
  assign expired = enable && (count == 16'(LIMIT - 1));

endmodule

// File: rtl/sysid_check_ctrl.sv
// rtl/sysid_check_ctrl.sv - boot-time SysID read/compare sequencer; optional SYSID_CHECK_TIMEOUT_EN
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1425347263,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 id_ok,
  output logic                 ts_ok,
  output logic                 timeout,
  output logic [RETRY_W-1:0]   retry_count,
  output logic [31:0]          captured_id,
  output logic [31:0]          captured_ts,
  output logic                 avm_address,
  output logic                 avm_read,
  input  logic                 avm_waitrequest,
  input  logic [31:0]          avm_readdata
);

  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  state_t state;
  logic   stall_expired;

`ifdef SYSID_CHECK_TIMEOUT_EN
  logic stall;
  assign stall = avm_read & avm_waitrequest;

  // Counter restarts whenever the bus is not stalled, so each read gets a fresh budget
  sysid_check_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (~stall),
    .enable  (stall),
    .expired (stall_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign stall_expired      = 1'b0;
`endif

  // Sequencer: issue both reads, compare, retry or report; every output is registered here
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      retry_count <= '0;
      captured_id <= '0;
      captured_ts <= '0;
      avm_address <= SYSID_ADDR_ID;
      avm_read    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RD_ID;
            busy        <= 1'b1;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            retry_count <= '0;
            captured_id <= '0;
            captured_ts <= '0;
            avm_address <= SYSID_ADDR_ID;
            avm_read    <= 1'b1;
          end
        end
        RD_ID, RD_TS: begin
          if (!avm_waitrequest) begin
            if (state == RD_ID) begin
              captured_id <= avm_readdata;
              avm_address <= SYSID_ADDR_TS;
              state       <= RD_TS;
            end else begin
              captured_ts <= avm_readdata;
              avm_read    <= 1'b0;
              state       <= CHECK;
            end
          end else if (stall_expired) begin
            // A hung slave ends the check outright; retrying would hang again
            avm_read <= 1'b0;
            timeout  <= 1'b1;
            pass     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        CHECK: begin
          id_ok <= (captured_id == EXPECTED_ID);
          ts_ok <= (captured_ts == EXPECTED_TIMESTAMP);
          if ((captured_id == EXPECTED_ID) && (captured_ts == EXPECTED_TIMESTAMP)) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (retry_count < RETRY_LIMIT) begin
            retry_count <= retry_count + 1'b1;
            avm_address <= SYSID_ADDR_ID;
            avm_read    <= 1'b1;
            state       <= RD_ID;
          end else begin
            pass  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy     <= 1'b0;
          avm_read <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb/tb_sysid_check_ctrl.sv - randomized self-checking bench for sysid_check_ctrl
module tb_sysid_check_ctrl;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1425347263;
  localparam int MAXR = 3;
  localparam int TOUT = 10;
  localparam int NEVER = 1 << 30;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass, id_ok, ts_ok, timeout;
  logic [2:0]  retry_count;
  logic [31:0] captured_id, captured_ts;
  logic        avm_address, avm_read;
  logic        avm_waitrequest = 1'b1;
  logic [31:0] avm_readdata = 32'd0;

  sysid_check_ctrl #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .MAX_RETRIES        (MAXR),
    .TIMEOUT_CYCLES     (TOUT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout         (timeout),
    .retry_count     (retry_count),
    .captured_id     (captured_id),
    .captured_ts     (captured_ts),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_total = 0;

  // Slave scenario: data returned and wait states per pass
  logic [31:0] sc_id [8];
  logic [31:0] sc_ts [8];
  int          sc_wid [8];
  int          sc_wts [8];

  // Expectations shared with the compare process
  int          exp_s = NEVER, exp_d = NEVER;
  logic        e_pass = 0, e_id = 0, e_ts = 0, e_to = 0;
  logic [2:0]  e_rc = 0;
  logic [31:0] e_cid = 0, e_cts = 0;
  int          last_s = 0, last_done = -1, done_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (!reset && avm_read && !avm_waitrequest) rd_total <= rd_total + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Avalon slave: stalls the configured number of cycles, garbage data while stalled
  int rd_idx = 0;
  int stall = 0;
  always @(negedge clock) begin
    if (reset || !avm_read) begin
      avm_waitrequest = 1'b1;
      stall = 0;
      if (!busy) rd_idx = 0;
    end else begin
      int p, w;
      p = (rd_idx / 2 > 7) ? 7 : rd_idx / 2;
      w = avm_address ? sc_wts[p] : sc_wid[p];
      if (stall < w) begin
        avm_waitrequest = 1'b1;
        avm_readdata = $urandom;
        stall++;
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata = avm_address ? sc_ts[p] : sc_id[p];
        stall = 0;
        rd_idx++;
      end
    end
  end

  // Reference: walk passes until both words match or retries run out
  task automatic model(output int extra, output int rc, output logic ep, output logic ei,
                       output logic et, output logic [31:0] ci, output logic [31:0] ct);
    int p;
    p = 0;
    extra = 0;
    forever begin
      extra += sc_wid[p] + sc_wts[p];
      ci = sc_id[p];
      ct = sc_ts[p];
      ei = (ci == EXP_ID);
      et = (ct == EXP_TS);
      if (ei && et) begin ep = 1'b1; break; end
      if (p == MAXR) begin ep = 1'b0; break; end
      p++;
      extra += 3;
    end
    rc = p;
  endtask

  // Cycle-by-cycle compare against the expected busy window and held results
  logic prev_read = 1'b0, prev_addr = 1'b0, wr_edge, in_win;
  initial begin : compare
    forever begin
      @(posedge clock);
      wr_edge = avm_waitrequest;
      #2;
      if (!reset) begin
        in_win = (cyc >= exp_s) && (cyc <= exp_d);
        chk("busy", busy, in_win);
        chk("done", done, cyc == exp_d);
        if (done) begin last_done = cyc; done_cnt++; end
        if (!in_win) chk("read_idle", avm_read, 0);
        if (prev_read && wr_edge && in_win && cyc != exp_d) begin
          chk("read_hold", avm_read, 1);
          chk("addr_hold", avm_address, prev_addr);
        end
        if (!in_win) begin
          chk("pass", pass, e_pass);
          chk("id_ok", id_ok, e_id);
          chk("ts_ok", ts_ok, e_ts);
          chk("timeout", timeout, e_to);
          chk("retry_count", retry_count, e_rc);
          chk("captured_id", captured_id, e_cid);
          chk("captured_ts", captured_ts, e_cts);
        end
      end
      prev_read = avm_read;
      prev_addr = avm_address;
    end
  end

  task automatic set_sc(input int w);
    for (int i = 0; i < 8; i++) begin
      sc_id[i] = EXP_ID;
      sc_ts[i] = EXP_TS;
      sc_wid[i] = w;
      sc_wts[i] = w;
    end
  endtask

  task automatic launch(input bit hold, input bit tmo);
    int extra, rc, base;
    logic ep, ei, et;
    logic [31:0] ci, ct;
    model(extra, rc, ep, ei, et, ci, ct);
    if (tmo) begin
      extra = TOUT - 3; rc = 0; ep = 0; ei = 0; et = 0; ci = 0; ct = 0;
    end
    @(negedge clock);
    base = rd_total;
    start = 1'b1;
    exp_s = cyc + 1;
    exp_d = exp_s + 3 + extra;
    last_s = exp_s;
    e_pass = ep; e_id = ei; e_ts = et; e_to = tmo; e_rc = rc[2:0]; e_cid = ci; e_cts = ct;
    @(negedge clock);
    if (!hold) start = 1'b0;
    while (cyc < exp_d + 1) @(negedge clock);
    if (hold) begin
      exp_s = exp_d + 2;
      exp_d = exp_s + 3 + extra;
      @(negedge clock);
      start = 1'b0;
      while (cyc < exp_d + 1) @(negedge clock);
      chk("reads_b2b", rd_total - base, 4 * (rc + 1));
    end else begin
      chk("reads", rd_total - base, tmo ? 0 : 2 * (rc + 1));
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0;
    bit found;
    set_sc(0);
    @(negedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_ok", {id_ok, ts_ok, timeout}, 0);
    chk("rst_rc", retry_count, 0);
    chk("rst_cid", captured_id, 0);
    chk("rst_cts", captured_ts, 0);
    chk("rst_read", avm_read, 0);
    chk("rst_addr", avm_address, 0);
    reset = 1'b0;

    // Zero-wait good image
    set_sc(0);
    launch(0, 0);
    chk("t1_latency", last_done - last_s, 3);
    chk("t1_pass", pass, 1);
    chk("t1_oks", {id_ok, ts_ok}, 2'b11);
    chk("t1_rc", retry_count, 0);

    // Timestamp always wrong: all retries consumed
    set_sc(0);
    for (int i = 0; i < 8; i++) sc_ts[i] = 32'h1234_5678;
    launch(0, 0);
    chk("t2_pass", pass, 0);
    chk("t2_oks", {id_ok, ts_ok}, 2'b10);
    chk("t2_rc", retry_count, 3);
    chk("t2_cts", captured_ts, 32'h1234_5678);

    // ID wrong in MSB only on first pass
    set_sc(0);
    sc_id[0] = 32'h8000_0000;
    launch(0, 0);
    chk("t3_pass", pass, 1);
    chk("t3_rc", retry_count, 1);

    // Five wait states per read
    set_sc(5);
    launch(0, 0);
    chk("t4_latency", last_done - last_s, 13);
    chk("t4_pass", pass, 1);

    // start held high: back-to-back checks
    set_sc(0);
    n0 = done_cnt;
    launch(1, 0);
    chk("b2b_dones", done_cnt - n0, 2);

    // Reset during the timestamp read
    set_sc(0);
    sc_wts[0] = 3;
    @(negedge clock);
    start = 1'b1;
    exp_s = cyc + 1;
    exp_d = exp_s + 6;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (avm_read && avm_address) begin found = 1; break; end
    end
    chk("reach_rd_ts", found, 1);
    n0 = done_cnt;
    @(posedge clock);
    #3;
    reset = 1'b1;
    exp_s = NEVER; exp_d = NEVER;
    e_pass = 0; e_id = 0; e_ts = 0; e_to = 0; e_rc = 0; e_cid = 0; e_cts = 0;
    #1;
    chk("rr_read", avm_read, 0);
    chk("rr_busy", busy, 0);
    chk("rr_cid", captured_id, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rr_nodone", done_cnt - n0, 0);
    set_sc(0);
    launch(0, 0);
    chk("rr_again", pass, 1);

`ifdef SYSID_CHECK_TIMEOUT_EN
    set_sc(0);
    sc_wid[0] = 1000;
    n0 = done_cnt;
    launch(0, 1);
    chk("to_flag", timeout, 1);
    chk("to_latency", last_done - last_s, TOUT);
    chk("to_dones", done_cnt - n0, 1);
`endif

    // Randomized images and wait states
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 8; i++) begin
        sc_wid[i] = $urandom_range(0, 3);
        sc_wts[i] = $urandom_range(0, 3);
        sc_id[i] = ($urandom_range(0, 3) == 0) ? (EXP_ID ^ (32'd1 << $urandom_range(0, 31))) : EXP_ID;
        sc_ts[i] = ($urandom_range(0, 3) == 0) ? (EXP_TS ^ ($urandom | 32'd1)) : EXP_TS;
      end
      launch(0, 0);
    end

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
